// File: rtl/mem_access_pkg.sv
// Shared definitions for the MEM-stage byte-serial memory responder:
// load/store op codes, FSM state encoding and small decode helpers.
package mem_access_pkg;

    // Default RAM byte-address width (RamAddrBus)
    localparam int RAM_ADDR_W = 17;

    // Load/store op codes carried on aluop
    localparam logic [7:0] OP_LB  = 8'hE0;
    localparam logic [7:0] OP_LH  = 8'hE1;
    localparam logic [7:0] OP_LW  = 8'hE3;
    localparam logic [7:0] OP_LBU = 8'hE4;
    localparam logic [7:0] OP_LHU = 8'hE5;
    localparam logic [7:0] OP_SB  = 8'hE8;
    localparam logic [7:0] OP_SH  = 8'hE9;
    localparam logic [7:0] OP_SW  = 8'hEB;

    typedef enum logic [1:0] {
        MEM_IDLE   = 2'd0,
        MEM_ACCESS = 2'd1,
        MEM_DONE   = 2'd2
    } mem_state_e;

    // Number of RAM bytes touched by an op; 0 marks an op this stage does not serve
    function automatic logic [2:0] op_nbytes(input logic [7:0] op);
        case (op)
            OP_LB, OP_LBU, OP_SB: op_nbytes = 3'd1;
            OP_LH, OP_LHU, OP_SH: op_nbytes = 3'd2;
            OP_LW, OP_SW:         op_nbytes = 3'd4;
            default:              op_nbytes = 3'd0;
        endcase
    endfunction

    function automatic logic op_legal(input logic [7:0] op);
        op_legal = (op_nbytes(op) != 3'd0);
    endfunction

    function automatic logic op_is_store(input logic [7:0] op);
        case (op)
            OP_SB, OP_SH, OP_SW: op_is_store = 1'b1;
            default:             op_is_store = 1'b0;
        endcase
    endfunction

    // Little-endian byte lane select
    function automatic logic [7:0] byte_sel(input logic [31:0] d, input logic [1:0] idx);
        case (idx)
            2'd0:    byte_sel = d[7:0];
            2'd1:    byte_sel = d[15:8];
            2'd2:    byte_sel = d[23:16];
            default: byte_sel = d[31:24];
        endcase
    endfunction

endpackage

// File: rtl/mem_access_if.sv
// Pipeline-side request/response signals plus the 8-bit RAM port of the MEM stage.
interface mem_access_if #(parameter int ADDR_W = 17) ();
    logic              mem_rw_i;
    logic [7:0]        aluop_i;
    logic [ADDR_W-1:0] mem_addr_i;
    logic [31:0]       mem_write_data_i;
    logic [4:0]        wd_i;
    logic              wreg_i;
    logic [31:0]       wdata_i;
    logic [4:0]        wd_o;
    logic              wreg_o;
    logic [31:0]       wdata_o;
    logic              stall_req_o;
    logic [ADDR_W-1:0] ram_addr_o;
    logic [7:0]        ram_dout_o;
    logic              ram_wr_o;
    logic [7:0]        ram_din_i;

    modport slave (
        input  mem_rw_i, aluop_i, mem_addr_i, mem_write_data_i, wd_i, wreg_i, wdata_i, ram_din_i,
        output wd_o, wreg_o, wdata_o, stall_req_o, ram_addr_o, ram_dout_o, ram_wr_o
    );

    modport master (
        output mem_rw_i, aluop_i, mem_addr_i, mem_write_data_i, wd_i, wreg_i, wdata_i, ram_din_i,
        input  wd_o, wreg_o, wdata_o, stall_req_o, ram_addr_o, ram_dout_o, ram_wr_o
    );
endinterface

// File: rtl/mem_access_load_ext.sv
// Sign/zero extension of an assembled load value according to the load op.
module mem_access_load_ext
    import mem_access_pkg::*;
(
    input  logic [7:0]  i_aluop,
    input  logic [31:0] i_raw,
    output logic [31:0] o_data
);

    // Select extension by load width and signedness; non-loads yield zero
    always_comb begin
        o_data = 32'd0;
        case (i_aluop)
            OP_LB:   o_data = {{24{i_raw[7]}}, i_raw[7:0]};
            OP_LBU:  o_data = {24'd0, i_raw[7:0]};
            OP_LH:   o_data = {{16{i_raw[15]}}, i_raw[15:0]};
            OP_LHU:  o_data = {16'd0, i_raw[15:0]};
            OP_LW:   o_data = i_raw;
            default: o_data = 32'd0;
        endcase
    end

endmodule

// File: rtl/mem_access.sv
// MEM-stage responder: turns one 32-bit load/store into byte-serial accesses on
// an 8-bit single-port RAM, stalling upstream until the result is ready.
module mem_access
    import mem_access_pkg::*;
#(
    parameter int ADDR_W  = RAM_ADDR_W,
    parameter int RAM_LAT = 1
) (
    input logic         clk,
    input logic         rst,
    mem_access_if.slave bus
);

    mem_state_e        r_state;
    logic [7:0]        r_op;
    logic [ADDR_W-1:0] r_addr;
    logic [31:0]       r_sdata;
    logic [4:0]        r_wd;
    logic              r_wreg;
    logic [7:0]        r_cnt;
    logic [31:0]       r_shift;
    logic [ADDR_W-1:0] r_ram_addr;
    logic [7:0]        r_ram_dout;
    logic              r_ram_wr;
    logic [4:0]        r_wd_out;
    logic              r_wreg_out;
    logic [31:0]       r_wdata_out;

    logic              w_req_ok;
    logic [2:0]        w_nbytes;
    logic              w_is_store;
    logic [7:0]        w_last_cnt;
    logic              w_capture;
    logic              w_more;
    logic [31:0]       w_shift_next;
    logic [31:0]       w_raw;
    logic [31:0]       w_ext;

    assign w_req_ok     = bus.mem_rw_i & op_legal(bus.aluop_i);
    assign w_nbytes     = op_nbytes(r_op);
    assign w_is_store   = op_is_store(r_op);
    // Stores finish after issuing n bytes; loads wait for the last byte's read latency
    assign w_last_cnt   = w_is_store ? ({5'd0, w_nbytes} - 8'd1)
                                     : ({5'd0, w_nbytes} + 8'(RAM_LAT) - 8'd2);
    assign w_capture    = (r_cnt >= 8'(RAM_LAT - 1));
    assign w_more       = ((r_cnt + 8'd1) < {5'd0, w_nbytes});
    assign w_shift_next = {bus.ram_din_i, r_shift[31:8]};

    // Bytes shift in from the top; right-align the n bytes actually read
    always_comb begin
        w_raw = w_shift_next;
        case (w_nbytes)
            3'd1:    w_raw = {24'd0, w_shift_next[31:24]};
            3'd2:    w_raw = {16'd0, w_shift_next[31:16]};
            default: w_raw = w_shift_next;
        endcase
    end

    mem_access_load_ext u_load_ext (
        .i_aluop (r_op),
        .i_raw   (w_raw),
        .o_data  (w_ext)
    );

    // Access FSM: latch request, step byte counter and RAM port, register the result
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= MEM_IDLE;
            r_op        <= 8'd0;
            r_addr      <= '0;
            r_sdata     <= 32'd0;
            r_wd        <= 5'd0;
            r_wreg      <= 1'b0;
            r_cnt       <= 8'd0;
            r_shift     <= 32'd0;
            r_ram_addr  <= '0;
            r_ram_dout  <= 8'd0;
            r_ram_wr    <= 1'b0;
            r_wd_out    <= 5'd0;
            r_wreg_out  <= 1'b0;
            r_wdata_out <= 32'd0;
        end else begin
            case (r_state)
                MEM_IDLE: begin
                    r_wd_out    <= 5'd0;
                    r_wreg_out  <= 1'b0;
                    r_wdata_out <= 32'd0;
                    if (w_req_ok) begin
                        r_op       <= bus.aluop_i;
                        r_addr     <= bus.mem_addr_i;
                        r_sdata    <= bus.mem_write_data_i;
                        r_wd       <= bus.wd_i;
                        r_wreg     <= bus.wreg_i;
                        r_cnt      <= 8'd0;
                        r_shift    <= 32'd0;
                        r_ram_addr <= bus.mem_addr_i;
                        r_ram_dout <= bus.mem_write_data_i[7:0];
                        r_ram_wr   <= op_is_store(bus.aluop_i);
                        r_state    <= MEM_ACCESS;
                    end else begin
                        r_ram_wr <= 1'b0;
                        r_state  <= MEM_IDLE;
                    end
                end
                MEM_ACCESS: begin
                    if (!w_is_store && w_capture) begin
                        r_shift <= w_shift_next;
                    end
                    if (r_cnt == w_last_cnt) begin
                        r_ram_wr    <= 1'b0;
                        r_wd_out    <= r_wd;
                        r_wreg_out  <= w_is_store ? 1'b0 : r_wreg;
                        r_wdata_out <= w_is_store ? 32'd0 : w_ext;
                        r_state     <= MEM_DONE;
                    end else begin
                        r_cnt <= r_cnt + 8'd1;
                        if (w_more) begin
                            r_ram_addr <= r_addr + ADDR_W'(r_cnt + 8'd1);
                            r_ram_dout <= byte_sel(r_sdata, r_cnt[1:0] + 2'd1);
                        end else begin
                            r_ram_wr <= 1'b0;
                        end
                    end
                end
                MEM_DONE: begin
                    r_wd_out    <= 5'd0;
                    r_wreg_out  <= 1'b0;
                    r_wdata_out <= 32'd0;
                    r_state     <= MEM_IDLE;
                end
                default: begin
                    r_ram_wr <= 1'b0;
                    r_state  <= MEM_IDLE;
                end
            endcase
        end
    end

    // Pipeline outputs: pass-through in IDLE, stall during access, registered result in DONE
    always_comb begin
        bus.wd_o        = 5'd0;
        bus.wreg_o      = 1'b0;
        bus.wdata_o     = 32'd0;
        bus.stall_req_o = 1'b0;
        if (rst) begin
            bus.stall_req_o = 1'b0;
        end else begin
            case (r_state)
                MEM_IDLE: begin
                    bus.wd_o        = bus.wd_i;
                    bus.wreg_o      = bus.mem_rw_i ? 1'b0 : bus.wreg_i;
                    bus.wdata_o     = bus.mem_rw_i ? 32'd0 : bus.wdata_i;
                    bus.stall_req_o = w_req_ok;
                end
                MEM_ACCESS: begin
                    bus.wd_o        = r_wd;
                    bus.stall_req_o = 1'b1;
                end
                MEM_DONE: begin
                    bus.wd_o    = r_wd_out;
                    bus.wreg_o  = r_wreg_out;
                    bus.wdata_o = r_wdata_out;
                end
                default: begin
                    bus.stall_req_o = 1'b0;
                end
            endcase
        end
    end

    assign bus.ram_addr_o = r_ram_addr;
    assign bus.ram_dout_o = r_ram_dout;
    assign bus.ram_wr_o   = r_ram_wr;

endmodule

// File: tb/tb_mem_access.sv
// Directed bench for mem_access: byte-serial stores/loads against a RAM model
// with one cycle of read latency, plus pass-through, illegal-op and reset abort.
module tb_mem_access;
    import mem_access_pkg::*;

    logic clk;
    logic rst;
    int   n_vec;
    int   n_err;

    logic [7:0] mem [0:131071];

    mem_access_if #(.ADDR_W(17)) bus ();

    mem_access #(.ADDR_W(17), .RAM_LAT(1)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // RAM model: synchronous write, combinational read
    always @(posedge clk) begin
        if (bus.ram_wr_o) mem[bus.ram_addr_o] <= bus.ram_dout_o;
    end
    assign bus.ram_din_i = mem[bus.ram_addr_o];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Issue one memory op at a negedge, count stall cycles, check DONE outputs
    task automatic do_op(input string tag, input logic [7:0] op, input logic [16:0] addr,
                         input logic [31:0] data, input logic [4:0] wd, input int exp_stall,
                         input logic exp_wreg, input logic [31:0] exp_wdata);
        int stall_cnt;
        bus.mem_rw_i         = 1'b1;
        bus.aluop_i          = op;
        bus.mem_addr_i       = addr;
        bus.mem_write_data_i = data;
        bus.wd_i             = wd;
        bus.wreg_i           = 1'b1;
        bus.wdata_i          = 32'h0BAD0BAD;
        #1;
        chk({tag, " req_wreg"}, 32'(bus.wreg_o), 32'd0);
        stall_cnt = 0;
        for (int i = 0; i < 20; i++) begin
            if (bus.stall_req_o) begin
                stall_cnt++;
                @(negedge clk);
                #1;
            end else begin
                break;
            end
        end
        chk({tag, " stall_cycles"}, 32'(stall_cnt), 32'(exp_stall));
        chk({tag, " done_wd"}, 32'(bus.wd_o), 32'(wd));
        chk({tag, " done_wreg"}, 32'(bus.wreg_o), 32'(exp_wreg));
        chk({tag, " done_wdata"}, bus.wdata_o, exp_wdata);
        bus.mem_rw_i = 1'b0;
        @(negedge clk);
        chk({tag, " idle_wr"}, 32'(bus.ram_wr_o), 32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    initial begin
        n_vec = 0;
        n_err = 0;
        rst = 1'b1;
        bus.mem_rw_i = 1'b0;
        bus.aluop_i = 8'd0;
        bus.mem_addr_i = 17'd0;
        bus.mem_write_data_i = 32'd0;
        bus.wd_i = 5'd0;
        bus.wreg_i = 1'b0;
        bus.wdata_i = 32'd0;

        // Reset state
        @(negedge clk);
        @(negedge clk);
        #1;
        chk("rst_stall", 32'(bus.stall_req_o), 32'd0);
        chk("rst_wr", 32'(bus.ram_wr_o), 32'd0);
        chk("rst_addr", 32'(bus.ram_addr_o), 32'd0);
        chk("rst_wdata", bus.wdata_o, 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // Non-memory pass-through
        bus.wd_i = 5'd5; bus.wreg_i = 1'b1; bus.wdata_i = 32'h00001234;
        #1;
        chk("pt_wd", 32'(bus.wd_o), 32'd5);
        chk("pt_wreg", 32'(bus.wreg_o), 32'd1);
        chk("pt_wdata", bus.wdata_o, 32'h00001234);
        chk("pt_stall", 32'(bus.stall_req_o), 32'd0);
        @(negedge clk);
        bus.wd_i = 5'd31; bus.wreg_i = 1'b0; bus.wdata_i = 32'hFFFF0000;
        #1;
        chk("pt2_wd", 32'(bus.wd_o), 32'd31);
        chk("pt2_wreg", 32'(bus.wreg_o), 32'd0);
        chk("pt2_wdata", bus.wdata_o, 32'hFFFF0000);
        @(negedge clk);

        // Illegal op: no stall, no RAM activity, zeroed result
        bus.mem_rw_i = 1'b1; bus.aluop_i = 8'h00; bus.wreg_i = 1'b1; bus.wdata_i = 32'h11111111;
        #1;
        chk("ill_stall", 32'(bus.stall_req_o), 32'd0);
        chk("ill_wreg", 32'(bus.wreg_o), 32'd0);
        chk("ill_wdata", bus.wdata_o, 32'd0);
        @(negedge clk);
        #1;
        chk("ill_wr", 32'(bus.ram_wr_o), 32'd0);
        chk("ill_stall2", 32'(bus.stall_req_o), 32'd0);
        bus.mem_rw_i = 1'b0;
        @(negedge clk);

        // SW then LW readback
        do_op("sw100", OP_SW, 17'h00100, 32'hDEADBEEF, 5'd7, 5, 1'b0, 32'd0);
        chk("sw100_b0", 32'(mem[17'h00100]), 32'h000000EF);
        chk("sw100_b1", 32'(mem[17'h00101]), 32'h000000BE);
        chk("sw100_b2", 32'(mem[17'h00102]), 32'h000000AD);
        chk("sw100_b3", 32'(mem[17'h00103]), 32'h000000DE);
        do_op("lw100", OP_LW, 17'h00100, 32'd0, 5'd9, 5, 1'b1, 32'hDEADBEEF);

        // Byte loads of 0x80
        do_op("sb200", OP_SB, 17'h00200, 32'h12345680, 5'd1, 2, 1'b0, 32'd0);
        chk("sb200_b0", 32'(mem[17'h00200]), 32'h00000080);
        do_op("lb200", OP_LB, 17'h00200, 32'd0, 5'd2, 2, 1'b1, 32'hFFFFFF80);
        do_op("lbu200", OP_LBU, 17'h00200, 32'd0, 5'd3, 2, 1'b1, 32'h00000080);

        // Halfword loads of bytes 0x00,0x80
        do_op("sh200", OP_SH, 17'h00200, 32'h00008000, 5'd4, 3, 1'b0, 32'd0);
        do_op("lh200", OP_LH, 17'h00200, 32'd0, 5'd10, 3, 1'b1, 32'hFFFF8000);
        do_op("lhu200", OP_LHU, 17'h00200, 32'd0, 5'd11, 3, 1'b1, 32'h00008000);

        // Address wrap-around
        do_op("shwrap", OP_SH, 17'h1FFFF, 32'h0000AABB, 5'd12, 3, 1'b0, 32'd0);
        chk("wrap_b0", 32'(mem[17'h1FFFF]), 32'h000000BB);
        chk("wrap_b1", 32'(mem[17'h00000]), 32'h000000AA);
        do_op("lhuwrap", OP_LHU, 17'h1FFFF, 32'd0, 5'd13, 3, 1'b1, 32'h0000AABB);

        // Reset in the middle of a store after two bytes
        do_op("sw300", OP_SW, 17'h00300, 32'h55555555, 5'd14, 5, 1'b0, 32'd0);
        bus.mem_rw_i = 1'b1; bus.aluop_i = OP_SW; bus.mem_addr_i = 17'h00300;
        bus.mem_write_data_i = 32'h44332211; bus.wd_i = 5'd15; bus.wreg_i = 1'b1;
        @(negedge clk);
        #1;
        chk("abort_wr_c0", 32'(bus.ram_wr_o), 32'd1);
        chk("abort_addr_c0", 32'(bus.ram_addr_o), 32'h00000300);
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("abort_rst_stall", 32'(bus.stall_req_o), 32'd0);
        @(negedge clk);
        #1;
        chk("abort_wr", 32'(bus.ram_wr_o), 32'd0);
        chk("abort_addr", 32'(bus.ram_addr_o), 32'd0);
        chk("abort_wd", 32'(bus.wd_o), 32'd0);
        chk("abort_wdata", bus.wdata_o, 32'd0);
        rst = 1'b0;
        bus.mem_rw_i = 1'b0;
        @(negedge clk);
        chk("abort_b0", 32'(mem[17'h00300]), 32'h00000011);
        chk("abort_b1", 32'(mem[17'h00301]), 32'h00000022);
        chk("abort_b2", 32'(mem[17'h00302]), 32'h00000055);
        chk("abort_b3", 32'(mem[17'h00303]), 32'h00000055);
        do_op("lw300", OP_LW, 17'h00300, 32'd0, 5'd16, 5, 1'b1, 32'h55552211);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
